// File: rtl/vec_issue_queue.sv
// Scalar-side issue buffer feeding vector decode: in-order FIFO of
// {inst, rs1, rs2}, with a config barrier that waits for the new vl.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   scalar_valid/ready    issue handshake from the scalar pipeline
//   scalar_inst/rs1/rs2   instruction word and captured operand values
//   vec_valid/ready       head handshake toward vector decode
//   vec_inst/rs1/rs2      FIFO head contents
//   cfg_done, cfg_vl      vector unit returns vl for a config instruction
//   wb_valid/rd/data      one-cycle scalar register writeback of vl
//   illegal               one-cycle pulse after accepting a non-vector opcode
//   count                 current FIFO occupancy
module vec_issue_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       scalar_valid,
    input  logic [XLEN-1:0]            scalar_inst,
    input  logic [XLEN-1:0]            scalar_rs1,
    input  logic [XLEN-1:0]            scalar_rs2,
    output logic                       scalar_ready,
    output logic                       vec_valid,
    output logic [XLEN-1:0]            vec_inst,
    output logic [XLEN-1:0]            vec_rs1,
    output logic [XLEN-1:0]            vec_rs2,
    input  logic                       vec_ready,
    input  logic                       cfg_done,
    input  logic [XLEN-1:0]            cfg_vl,
    output logic                       wb_valid,
    output logic [4:0]                 wb_rd,
    output logic [XLEN-1:0]            wb_data,
    output logic                       illegal,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {
        RUN,
        CFG_WAIT
    } state_t;

    state_t state, state_nxt;

    logic [XLEN-1:0] mem_inst [DEPTH];
    logic [XLEN-1:0] mem_rs1  [DEPTH];
    logic [XLEN-1:0] mem_rs2  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [4:0]    cfg_rd;

    logic full;
    logic empty;
    logic accept;
    logic is_vec;
    logic is_cfg;
    logic push;
    logic pop;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign accept = scalar_valid && scalar_ready;
    assign push   = accept && is_vec;
    assign pop    = vec_valid && vec_ready;

    always_comb begin
        is_vec = 1'b0;
        unique case (scalar_inst[6:0])
            7'h57:   is_vec = 1'b1;
            7'h07:   is_vec = 1'b1;
            7'h27:   is_vec = 1'b1;
            default: is_vec = 1'b0;
        endcase
    end

    assign is_cfg = (scalar_inst[6:0] == 7'h57)
                 && (scalar_inst[14:12] == 3'b111);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN: begin
                if (accept && is_cfg) begin
                    state_nxt = CFG_WAIT;
                end
            end
            CFG_WAIT: begin
                if (cfg_done) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Output logic: ready depends only on registered state and count
    always_comb begin
        scalar_ready = 1'b0;
        unique case (state)
            RUN:      scalar_ready = !full;
            CFG_WAIT: scalar_ready = 1'b0;
            default:  scalar_ready = 1'b0;
        endcase
    end

    // Entry storage needs no reset; only occupancy makes it visible
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= scalar_inst;
            mem_rs1[wr_ptr]  <= scalar_rs1;
            mem_rs2[wr_ptr]  <= scalar_rs2;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign vec_valid = !empty;
    assign vec_inst  = mem_inst[rd_ptr];
    assign vec_rs1   = mem_rs1[rd_ptr];
    assign vec_rs2   = mem_rs2[rd_ptr];

    // Destination of the pending config instruction
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rd <= '0;
        end else if (state == RUN && accept && is_cfg) begin
            cfg_rd <= scalar_inst[11:7];
        end
    end

    // Writeback of the returned vl; x0 destinations are suppressed
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (state == CFG_WAIT && cfg_done) begin
                wb_valid <= (cfg_rd != 5'd0);
                wb_rd    <= cfg_rd;
                wb_data  <= cfg_vl;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal <= 1'b0;
        end else begin
            illegal <= accept && !is_vec;
        end
    end

endmodule
